// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Widest operand the constant helpers can describe.
  localparam int MAX_W = 64;

  // Iteration counter width. It holds WIDTH-1 at most.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

  // Divide-by-zero quotient: all ones in the low 'width' bits.
  function automatic logic [MAX_W-1:0] dz_quotient(input int width);
    return {MAX_W{1'b1}} >> (MAX_W - width);
  endfunction

  // Signed overflow quotient: the most negative value, 100..0.
  function automatic logic [MAX_W-1:0] ovf_quotient(input int width);
    return {{(MAX_W-1){1'b0}}, 1'b1} << (width - 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift the next dividend
// bit into the partial remainder, then trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // Trial subtraction at WIDTH+1 bits. The shifted remainder can need the
  // extra bit, and trial[WIDTH] is the borrow (negative) indicator.
  // NOTE: every signal written in always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    trial    = {rem, shift_in} - {1'b0, divisor};
    q_bit    = ~trial[WIDTH];
    rem_next = q_bit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], shift_in};
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring integer divider with a start/done handshake.
// Produces one quotient bit per clock and flags divide-by-zero and signed
// overflow.
// Optional feature: define DIV_SIGNED_EN to honour signed_op (two's-complement
// divide). Without it, every operation is unsigned and ovf stays 0.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dzf,
  output logic             ovf
);

  localparam int               CW      = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] DZ_Q    = WIDTH'(dz_quotient(WIDTH));
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(ovf_quotient(WIDTH));

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo_sh;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_step;
  logic             q_bit;
  logic             accept, is_dz, is_ovf;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign accept = start && (state == IDLE || state == DONE);
  assign is_dz  = (divisor == '0);

`ifdef DIV_SIGNED_EN
  logic dvd_neg, dvs_neg;
  logic neg_q, neg_r;

  assign dvd_neg = signed_op & dividend[WIDTH-1];
  assign dvs_neg = signed_op & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;
  assign is_ovf  = signed_op && (dividend == MIN_NEG) && (divisor == '1);
  // Truncating division: quotient sign is the XOR, remainder follows dividend.
  assign quo_fix = neg_q ? -quo_sh : quo_sh;
  assign rem_fix = neg_r ? -rem_q : rem_q;

  // Latch the sign bookkeeping and the overflow flag on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      neg_q <= dvd_neg ^ dvs_neg;
      neg_r <= dvd_neg;
      ovf   <= is_ovf;
    end
  end
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign is_ovf  = 1'b0;
  assign quo_fix = quo_sh;
  assign rem_fix = rem_q;
  assign ovf     = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .shift_in (quo_sh[WIDTH-1]),
    .divisor  (dvs_q),
    .rem_next (rem_step),
    .q_bit    (q_bit)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; special cases skip CALC and FIX entirely.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: state_nx = start ? ((is_dz || is_ovf) ? DONE : CALC) : IDLE;
      CALC:       if (cnt == '0) state_nx = FIX;
      FIX:        state_nx = DONE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      CALC, FIX: busy = 1'b1;
      DONE:      done = 1'b1;
      default:   ;
    endcase
  end

  // Datapath: load on accept, iterate in CALC, publish results in FIX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      quo_sh    <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      dzf       <= 1'b0;
    end else if (accept) begin
      cnt    <= CW'(WIDTH - 1);
      quo_sh <= dvd_mag;
      rem_q  <= '0;
      dvs_q  <= dvs_mag;
      dzf    <= is_dz;
      if (is_dz) begin
        quotient  <= DZ_Q;
        remainder <= dividend;
      end else if (is_ovf) begin
        quotient  <= MIN_NEG;
        remainder <= '0;
      end
    end else if (state == CALC) begin
      quo_sh <= {quo_sh[WIDTH-2:0], q_bit};
      rem_q  <= rem_step;
      cnt    <= cnt - CW'(1);
    end else if (state == FIX) begin
      quotient  <= quo_fix;
      remainder <= rem_fix;
    end
  end

endmodule
